// File: rtl/vga_sync_gen_if.sv
// Sync/timing bundle produced by vga_sync_gen; master drives, slave observes.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;

  modport master (
    output hsync, vsync, video_on, p_tick, frame_tick, pix_x, pix_y
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, frame_tick, pix_x, pix_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: /4 pixel strobe, h/v counters and registered sync/blank.
// Defaults give 640x480 with 800x525 totals; geometry is parameterised.
module vga_sync_gen #(
  parameter int unsigned HVisible = 640,
  parameter int unsigned HFront   = 16,
  parameter int unsigned HSync    = 96,
  parameter int unsigned HBack    = 48,
  parameter int unsigned VVisible = 480,
  parameter int unsigned VFront   = 10,
  parameter int unsigned VSync    = 2,
  parameter int unsigned VBack    = 33
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam logic [9:0] HMax       = 10'(HVisible + HFront + HSync + HBack - 1);
  localparam logic [9:0] VMax       = 10'(VVisible + VFront + VSync + VBack - 1);
  localparam logic [9:0] HVisEnd    = 10'(HVisible);
  localparam logic [9:0] VVisEnd    = 10'(VVisible);
  localparam logic [9:0] HSyncStart = 10'(HVisible + HFront);
  localparam logic [9:0] HSyncEnd   = 10'(HVisible + HFront + HSync);
  localparam logic [9:0] VSyncStart = 10'(VVisible + VFront);
  localparam logic [9:0] VSyncEnd   = 10'(VVisible + VFront + VSync);

  logic [1:0] q_q, q_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, vsync_q, video_on_q, frame_tick_q;
  logic       tick;
  logic       h_wrap;
  logic       v_wrap;

  assign tick   = (q_q == 2'd3);
  assign h_wrap = (h_q == HMax);
  assign v_wrap = (v_q == VMax);

  always_comb begin
    q_d = q_q + 2'd1;
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Sync/blank flops decode the next-state counters so they line up with pix_x/pix_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q          <= '0;
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= !((h_d >= HSyncStart) && (h_d < HSyncEnd));
      vsync_q      <= !((v_d >= VSyncStart) && (v_d < VSyncEnd));
      video_on_q   <= (h_d < HVisEnd) && (v_d < VVisEnd);
      frame_tick_q <= tick && h_wrap && v_wrap;
    end
  end

  assign vga.p_tick     = tick;
  assign vga.pix_x      = h_q;
  assign vga.pix_y      = v_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size and scaled-geometry instances checked each cycle
// against an arithmetic raster model, plus directed literal checks.
module tb_vga_sync_gen;

  typedef struct packed {
    int unsigned h_vis, h_fp, h_sync, h_bp;
    int unsigned v_vis, v_fp, v_sync, v_bp;
  } geom_t;

  localparam geom_t GFull  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geom_t GSmall = '{16, 4, 6, 6, 12, 3, 2, 4};
  localparam int unsigned SmallFrame = 32 * 21 * 4;

  logic clk = 1'b0;
  logic reset_full = 1'b1;
  logic reset_small = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if f_if ();
  vga_sync_gen_if s_if ();

  vga_sync_gen u_full (
    .clk   (clk),
    .reset (reset_full),
    .vga   (f_if)
  );

  vga_sync_gen #(
    .HVisible (16), .HFront (4), .HSync (6), .HBack (6),
    .VVisible (12), .VFront (3), .VSync (2), .VBack (4)
  ) u_small (
    .clk   (clk),
    .reset (reset_small),
    .vga   (s_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: clk cycles elapsed since the last edge that sampled reset high.
  int unsigned c_full = 0, c_small = 0;
  logic valid_full = 1'b0, valid_small = 1'b0;

  always @(posedge clk) begin
    if (reset_full) begin
      c_full <= 0;
      valid_full <= 1'b1;
    end else begin
      c_full <= c_full + 1;
    end
    if (reset_small) begin
      c_small <= 0;
      valid_small <= 1'b1;
    end else begin
      c_small <= c_small + 1;
    end
  end

  function automatic void model(input int unsigned c, input geom_t g,
                                output logic [9:0] x, output logic [9:0] y,
                                output logic hs, output logic vs, output logic vid,
                                output logic pt, output logic ft);
    int unsigned ht, vt, px, py;
    ht  = g.h_vis + g.h_fp + g.h_sync + g.h_bp;
    vt  = g.v_vis + g.v_fp + g.v_sync + g.v_bp;
    px  = (c / 4) % ht;
    py  = (c / (4 * ht)) % vt;
    x   = 10'(px);
    y   = 10'(py);
    pt  = (c % 4 == 3);
    vid = (c != 0) && (px < g.h_vis) && (py < g.v_vis);
    hs  = !((px >= g.h_vis + g.h_fp) && (px < g.h_vis + g.h_fp + g.h_sync));
    vs  = !((py >= g.v_vis + g.v_fp) && (py < g.v_vis + g.v_fp + g.v_sync));
    ft  = (c != 0) && (c % (4 * ht * vt) == 0);
  endfunction

  task automatic check_dut(input string name, input int unsigned c, input geom_t g,
                           input logic [9:0] x, input logic [9:0] y, input logic hs,
                           input logic vs, input logic vid, input logic pt, input logic ft);
    logic [9:0] ex, ey;
    logic ehs, evs, evid, ept, eft;
    model(c, g, ex, ey, ehs, evs, evid, ept, eft);
    n_cmp++;
    if ({x, y, hs, vs, vid, pt, ft} !== {ex, ey, ehs, evs, evid, ept, eft}) begin
      n_bad++;
      $display("FAIL %s c=%0d got x=%0d y=%0d hs=%b vs=%b vid=%b pt=%b ft=%b want x=%0d y=%0d hs=%b vs=%b vid=%b pt=%b ft=%b",
               name, c, x, y, hs, vs, vid, pt, ft, ex, ey, ehs, evs, evid, ept, eft);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (valid_full) begin
      check_dut("full_model", c_full, GFull, f_if.pix_x, f_if.pix_y, f_if.hsync, f_if.vsync,
                f_if.video_on, f_if.p_tick, f_if.frame_tick);
      n_cmp++;
      if (f_if.pix_x > 10'd799 || f_if.pix_y > 10'd524) begin
        n_bad++;
        $display("FAIL full_range got x=%0d y=%0d want x<=799 y<=524", f_if.pix_x, f_if.pix_y);
      end
    end
    if (valid_small) begin
      check_dut("small_model", c_small, GSmall, s_if.pix_x, s_if.pix_y, s_if.hsync, s_if.vsync,
                s_if.video_on, s_if.p_tick, s_if.frame_tick);
    end
  end

  task automatic check_reset_state(input string name, input logic [9:0] x, input logic [9:0] y,
                                   input logic hs, input logic vs, input logic vid,
                                   input logic pt, input logic ft);
    expect_eq({name, "_x"},   32'(x), 0);
    expect_eq({name, "_y"},   32'(y), 0);
    expect_eq({name, "_hs"},  32'(hs), 1);
    expect_eq({name, "_vs"},  32'(vs), 1);
    expect_eq({name, "_vid"}, 32'(vid), 0);
    expect_eq({name, "_pt"},  32'(pt), 0);
    expect_eq({name, "_ft"},  32'(ft), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_cnt, fall_x, rise_x, vs_lo, vid_hi, span;
    logic prev_hs, hit;

    repeat (3) @(negedge clk);
    check_reset_state("rst_full", f_if.pix_x, f_if.pix_y, f_if.hsync, f_if.vsync,
                      f_if.video_on, f_if.p_tick, f_if.frame_tick);
    reset_full  = 1'b0;
    reset_small = 1'b0;

    // Release: pix_x holds 0 for 4 clks, p_tick first in cycle 3.
    for (int k = 0; k <= 8; k++) begin
      expect_eq($sformatf("rel_px_c%0d", k), 32'(f_if.pix_x), (k < 4) ? 0 : (k < 8 ? 1 : 2));
      expect_eq($sformatf("rel_pt_c%0d", k), 32'(f_if.p_tick), (k % 4 == 3) ? 1 : 0);
      if (k == 1) expect_eq("rel_vid_c1", 32'(f_if.video_on), 1);
      @(negedge clk);
    end

    // First full line: hsync low span.
    lo_cnt = 0; fall_x = -1; rise_x = -1;
    prev_hs = f_if.hsync;
    for (int k = 9; k < 3200 + 8; k++) begin
      if (!f_if.hsync) lo_cnt++;
      if (prev_hs && !f_if.hsync) fall_x = int'(f_if.pix_x);
      if (!prev_hs && f_if.hsync) rise_x = int'(f_if.pix_x);
      prev_hs = f_if.hsync;
      @(negedge clk);
    end
    expect_eq("hsync_low_clks", 32'(lo_cnt), 384);
    expect_eq("hsync_fall_x", 32'(fall_x), 656);
    expect_eq("hsync_rise_x", 32'(rise_x), 752);

    // Mid-line reset on the full instance at (700,1), q==2.
    hit = 1'b0;
    for (int k = 0; k < 8000 && !hit; k++) begin
      if (f_if.pix_x == 10'd700 && f_if.pix_y == 10'd1 && c_full % 4 == 2) hit = 1'b1;
      else @(negedge clk);
    end
    expect_eq("full_rst_point_reached", 32'(hit), 1);
    reset_full = 1'b1;
    @(negedge clk);
    check_reset_state("midrst_full", f_if.pix_x, f_if.pix_y, f_if.hsync, f_if.vsync,
                      f_if.video_on, f_if.p_tick, f_if.frame_tick);
    reset_full = 1'b0;

    // Random reset pulses on the small instance; the per-cycle model covers recovery.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(3000, 1)) @(negedge clk);
      reset_small = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      reset_small = 1'b0;
    end

    // Frame-level measurement between two frame_tick pulses on the small instance.
    hit = 1'b0;
    for (int k = 0; k < 2 * SmallFrame && !hit; k++) begin
      if (s_if.frame_tick) hit = 1'b1;
      else @(negedge clk);
    end
    expect_eq("frame_tick_first_seen", 32'(hit), 1);
    expect_eq("corner_x", 32'(s_if.pix_x), 0);
    expect_eq("corner_y", 32'(s_if.pix_y), 0);
    expect_eq("corner_vid", 32'(s_if.video_on), 1);
    vs_lo = 0; vid_hi = 0; span = 0; hit = 1'b0;
    for (int k = 0; k < 2 * SmallFrame && !hit; k++) begin
      if (!s_if.vsync) vs_lo++;
      if (s_if.video_on) vid_hi++;
      if (s_if.video_on && (s_if.pix_x >= 10'd16 || s_if.pix_y >= 10'd12)) begin
        n_bad++;
        $display("FAIL vid_outside got x=%0d y=%0d want blank", s_if.pix_x, s_if.pix_y);
      end
      span++;
      @(negedge clk);
      if (s_if.frame_tick) hit = 1'b1;
    end
    expect_eq("frame_tick_second_seen", 32'(hit), 1);
    expect_eq("frame_period_clks", 32'(span), SmallFrame);
    expect_eq("vsync_low_clks", 32'(vs_lo), 2 * 32 * 4);
    expect_eq("video_on_clks", 32'(vid_hi), 16 * 12 * 4);
    @(negedge clk);
    expect_eq("frame_tick_one_clk", 32'(s_if.frame_tick), 0);

    // Reset in back porch of the last vsync row with q==2.
    hit = 1'b0;
    for (int k = 0; k < 2 * SmallFrame && !hit; k++) begin
      if (s_if.pix_x == 10'd28 && s_if.pix_y == 10'd16 && c_small % 4 == 2) hit = 1'b1;
      else @(negedge clk);
    end
    expect_eq("small_rst_point_reached", 32'(hit), 1);
    expect_eq("small_rst_pre_vs", 32'(s_if.vsync), 0);
    reset_small = 1'b1;
    @(negedge clk);
    check_reset_state("midrst_small", s_if.pix_x, s_if.pix_y, s_if.hsync, s_if.vsync,
                      s_if.video_on, s_if.p_tick, s_if.frame_tick);
    reset_small = 1'b0;
    repeat (50) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset. Only these two ports are listed here; parameters and all other ports follow.
REQ-002 clk  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-004 hsync  output  1  horizontal sync, active-low, registered.
REQ-005 vsync  output  1  vertical sync, active-low, registered.
REQ-006 video_on  output  1  high while the current pixel is in the 640x480 visible area, registered.
REQ-007 p_tick  output  1  pixel-rate strobe, one clk wide, once every 4 clk cycles.
REQ-008 pix_x  output  10  current column, 0..799.
REQ-009 pix_y  output  10  current row, 0..524.
REQ-010 frame_tick  output  1  one-clk pulse when the counters wrap from (799,524) to (0,0).

Function
REQ-011 A 2-bit divider counter q SHALL increment every clk cycle, wrapping 3->0.
REQ-012 p_tick SHALL be 1 exactly in the cycles where q==3.
REQ-013 The horizontal counter h SHALL advance only on an edge where q==3. At that edge h SHALL go from 799 to 0; otherwise it SHALL increment by 1.
REQ-014 The vertical counter v SHALL advance only on an edge where q==3 and h==799. At that edge v SHALL go from 524 to 0; otherwise it SHALL increment by 1.
REQ-015 pix_x SHALL equal h and pix_y SHALL equal v, with no added delay.
REQ-016 Horizontal timing SHALL be: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799 (800 total).
REQ-017 Vertical timing SHALL be: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524 (525 total).
REQ-018 hsync SHALL be low exactly while pix_x is in 656..751.
REQ-019 vsync SHALL be low exactly while pix_y is in 490..491.
REQ-020 video_on SHALL be high exactly while pix_x<640 and pix_y<480.
REQ-021 hsync, vsync and video_on SHALL be registered from next-state counter values, so there is zero clk skew relative to pix_x and pix_y.
REQ-022 hsync, vsync and video_on SHALL be glitch-free flop outputs.
REQ-023 frame_tick SHALL be high for the single clk cycle immediately after the edge where h and v both wrap to 0.
REQ-024 pix_x, pix_y, hsync, vsync and video_on SHALL change only on the clk edge that follows a p_tick cycle. The one exception is the reset-release edge, covered in REQ-028.
REQ-025 Each pixel position SHALL be held for exactly 4 clk cycles.
REQ-026 A frame SHALL be exactly 800*525*4 = 1,680,000 clk cycles.
REQ-027 All arithmetic SHALL be unsigned 10-bit. The counters SHALL never present values above 799 (h) or 524 (v).

Reset
REQ-028 While reset is high at a clk edge, the outputs SHALL load: q=0, pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=0, p_tick=0, frame_tick=0.
REQ-029 On the first edge after reset deasserts, video_on SHALL load 1 (position 0,0 is visible) and the counters SHALL hold at 0.
REQ-029a In the clk cycles after reset deasserts, p_tick SHALL first be high in the 4th cycle (q==3).
REQ-030 Reset asserted mid-frame SHALL take effect at the next clk edge, regardless of q, h or v. No partial frame_tick SHALL be emitted.

Verification
REQ-031 The bench SHALL cover: release reset -> pix_x=0 for 4 clks, then pix_x=1. p_tick is high in clk cycles 3, 7, 11... after release.
REQ-032 The bench SHALL cover: run one line -> hsync low for exactly 96*4=384 clks, starting when pix_x becomes 656 and ending when pix_x becomes 752.
REQ-033 The bench SHALL cover: run one frame -> vsync low for exactly 2*800*4=6400 clks, while pix_y is in 490..491.
REQ-033a In the same frame run, frame_tick SHALL pulse once, 1,680,000 clks after the previous pulse.
REQ-034 The bench SHALL cover: video_on scoreboard over a full frame -> high for exactly 640*480*4=1,228,800 clks, and never high when pix_x>=640 or pix_y>=480.
REQ-035 The bench SHALL cover: corner wrap at (799,524) -> the next pixel is (0,0) with video_on=1 and frame_tick=1 for one clk.
REQ-035a The bench SHALL check that pix_x never reads 800 and pix_y never reads 525.
REQ-036 The bench SHALL cover: assert reset at (700,491) with q=2 -> the next edge gives pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=0, p_tick=0.
